twofish_iter_core: RTL and testbench

//  Iterative Twofish block cipher core, one round per clock, for 128/192/256-bit keys.

---
 rtl/twofish_iter_core.sv | 229 ++++++++++++++++++++++
 tb/tb_twofish_iter_core.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/twofish_iter_core.sv
// Iterative Twofish block cipher core: one round per clock, 128/192/256-bit keys.
// Round subkeys are expanded once per key into a 40x32 register file, two words per cycle.
module twofish_iter_core #(
  parameter int KEY_BITS = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [255:0] key,
  output logic         key_ready,
  input  logic         start,
  input  logic         enc_dec,
  input  logic [127:0] text_input,
  output logic [127:0] text_output,
  output logic         busy,
  output logic         end_signal
);

  localparam int unsigned KW = KEY_BITS / 64;
  localparam logic [127:0] WMASK = (128'(1) << (32 * KW)) - 128'(1);

  // q-permutation nibble tables, entry 0 in the least significant nibble
  localparam logic [63:0] Q0T0 = 64'h4ACE95B023F6D718;
  localparam logic [63:0] Q0T1 = 64'hD9076A4F53218BCE;
  localparam logic [63:0] Q0T2 = 64'h17423F8C09D6E5AB;
  localparam logic [63:0] Q0T3 = 64'hAC5803B9E6214F7D;
  localparam logic [63:0] Q1T0 = 64'h5CA04913E67FDB82;
  localparam logic [63:0] Q1T1 = 64'h809F5AD673C4B2E1;
  localparam logic [63:0] Q1T2 = 64'hF3B28DE0A96157C4;
  localparam logic [63:0] Q1T3 = 64'hA802F746ED3C159B;

  localparam logic [7:0] RS [4][8] = '{
    '{8'h01, 8'hA4, 8'h55, 8'h87, 8'h5A, 8'h58, 8'hDB, 8'h9E},
    '{8'hA4, 8'h56, 8'h82, 8'hF3, 8'h1E, 8'hC6, 8'h68, 8'hE5},
    '{8'h02, 8'hA1, 8'hFC, 8'hC1, 8'h47, 8'hAE, 8'h3D, 8'h19},
    '{8'hA4, 8'h55, 8'h87, 8'h5A, 8'h58, 8'hDB, 8'h9E, 8'h03}
  };

  typedef enum logic [1:0] {IDLE, KEY_EXP, READY, CRYPT} state_t;

  function automatic logic [7:0] q_perm(input logic sel, input logic [7:0] x);
    logic [63:0] t0, t1, t2, t3;
    logic [3:0]  a, b, a2, b2;
    t0 = sel ? Q1T0 : Q0T0;
    t1 = sel ? Q1T1 : Q0T1;
    t2 = sel ? Q1T2 : Q0T2;
    t3 = sel ? Q1T3 : Q0T3;
    a  = x[7:4] ^ x[3:0];
    b  = x[7:4] ^ {x[0], x[3:1]} ^ {x[4], 3'b000};
    a2 = t0[{a, 2'b00} +: 4];
    b2 = t1[{b, 2'b00} +: 4];
    a  = a2 ^ b2;
    b  = a2 ^ {b2[0], b2[3:1]} ^ {a2[0], 3'b000};
    return {t3[{b, 2'b00} +: 4], t2[{a, 2'b00} +: 4]};
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] poly);
    logic [7:0] p, aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? poly : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] mds(input logic [7:0] y0, input logic [7:0] y1,
                                      input logic [7:0] y2, input logic [7:0] y3);
    logic [7:0] z0, z1, z2, z3;
    z0 = y0 ^ gf_mul(y1, 8'hEF, 8'h69) ^ gf_mul(y2, 8'h5B, 8'h69) ^ gf_mul(y3, 8'h5B, 8'h69);
    z1 = gf_mul(y0, 8'h5B, 8'h69) ^ gf_mul(y1, 8'hEF, 8'h69) ^ gf_mul(y2, 8'hEF, 8'h69) ^ y3;
    z2 = gf_mul(y0, 8'hEF, 8'h69) ^ gf_mul(y1, 8'h5B, 8'h69) ^ y2 ^ gf_mul(y3, 8'hEF, 8'h69);
    z3 = gf_mul(y0, 8'hEF, 8'h69) ^ y1 ^ gf_mul(y2, 8'hEF, 8'h69) ^ gf_mul(y3, 8'h5B, 8'h69);
    return {z3, z2, z1, z0};
  endfunction

  function automatic logic [31:0] h_fn(input logic [31:0] x, input logic [127:0] l);
    logic [7:0] y0, y1, y2, y3;
    {y3, y2, y1, y0} = x;
    if (KW == 4) begin
      y0 = q_perm(1'b1, y0) ^ l[103:96];
      y1 = q_perm(1'b0, y1) ^ l[111:104];
      y2 = q_perm(1'b0, y2) ^ l[119:112];
      y3 = q_perm(1'b1, y3) ^ l[127:120];
    end
    if (KW >= 3) begin
      y0 = q_perm(1'b1, y0) ^ l[71:64];
      y1 = q_perm(1'b1, y1) ^ l[79:72];
      y2 = q_perm(1'b0, y2) ^ l[87:80];
      y3 = q_perm(1'b0, y3) ^ l[95:88];
    end
    y0 = q_perm(1'b1, q_perm(1'b0, q_perm(1'b0, y0) ^ l[39:32]) ^ l[7:0]);
    y1 = q_perm(1'b0, q_perm(1'b0, q_perm(1'b1, y1) ^ l[47:40]) ^ l[15:8]);
    y2 = q_perm(1'b1, q_perm(1'b1, q_perm(1'b0, y2) ^ l[55:48]) ^ l[23:16]);
    y3 = q_perm(1'b0, q_perm(1'b1, q_perm(1'b1, y3) ^ l[63:56]) ^ l[31:24]);
    return mds(y0, y1, y2, y3);
  endfunction

  function automatic logic [31:0] rs_word(input logic [63:0] m);
    logic [31:0] s;
    s = '0;
    for (int unsigned r = 0; r < 4; r++)
      for (int unsigned c = 0; c < 8; c++)
        s[8*r +: 8] ^= gf_mul(RS[r][c], m[8*c +: 8], 8'h4D);
    return s;
  endfunction

  state_t       state, state_nxt;
  logic [4:0]   cnt;
  logic         dec_q;
  logic [127:0] me_q, mo_q, s_q, me_d, mo_d, s_d;
  logic [31:0]  sk [40];
  logic [31:0]  r0, r1, r2, r3;
  logic         kx, key_acc, start_acc;
  logic [7:0]   ev_byte, od_byte;
  logic [31:0]  ha, hb, hb_rol, f0, f1, n0, n1, k_even, k_odd, t_odd;
  logic [3:0]   rnd;
  logic [5:0]   ka_idx;
  logic [31:0]  wi0, wi1, wi2, wi3, wo0, wo1, wo2, wo3;

  assign kx        = (state == KEY_EXP);
  assign key_acc   = key_load && (state == IDLE || state == READY);
  assign start_acc = start && !key_load && (state == READY);
  assign ev_byte   = {2'b00, cnt, 1'b0};
  assign od_byte   = {2'b00, cnt, 1'b1};

  // Key words split into even/odd lists and RS-derived S words (S[k-1] in slot 0)
  always_comb begin
    me_d = {key[223:192], key[159:128], key[95:64], key[31:0]} & WMASK;
    mo_d = {key[255:224], key[191:160], key[127:96], key[63:32]} & WMASK;
    s_d  = '0;
    for (int unsigned i = 0; i < KW; i++)
      s_d[32*(KW-1-i) +: 32] = rs_word(key[64*i +: 64]);
  end

  // The two h() instances serve the key schedule in KEY_EXP and g() in CRYPT
  always_comb begin
    ha     = h_fn(kx ? {4{ev_byte}} : r0, kx ? me_q : s_q);
    hb     = h_fn(kx ? {4{od_byte}} : {r1[23:0], r1[31:24]}, kx ? mo_q : s_q);
    hb_rol = {hb[23:0], hb[31:24]};
    k_even = ha + hb_rol;
    t_odd  = ha + {hb_rol[30:0], 1'b0};
    k_odd  = {t_odd[22:0], t_odd[31:23]};
    rnd    = dec_q ? (4'd0 - cnt[3:0]) : (cnt[3:0] - 4'd1);
    ka_idx = 6'd8 + {1'b0, rnd, 1'b0};
    f0     = ha + hb + sk[ka_idx];
    f1     = ha + {hb[30:0], 1'b0} + sk[{ka_idx[5:1], 1'b1}];
    n0     = dec_q ? ({r2[30:0], r2[31]} ^ f0) : ((r2 ^ f0) >> 1 | (r2 ^ f0) << 31);
    n1     = dec_q ? ((r3 ^ f1) >> 1 | (r3 ^ f1) << 31) : ({r3[30:0], r3[31]} ^ f1);
    wi0 = dec_q ? sk[4] : sk[0];  wi1 = dec_q ? sk[5] : sk[1];
    wi2 = dec_q ? sk[6] : sk[2];  wi3 = dec_q ? sk[7] : sk[3];
    wo0 = dec_q ? sk[0] : sk[4];  wo1 = dec_q ? sk[1] : sk[5];
    wo2 = dec_q ? sk[2] : sk[6];  wo3 = dec_q ? sk[3] : sk[7];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; key_load wins over start in READY
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (key_load) state_nxt = KEY_EXP;
      KEY_EXP: if (cnt == 5'd19) state_nxt = READY;
      READY:   if (key_load) state_nxt = KEY_EXP;
               else if (start) state_nxt = CRYPT;
      CRYPT:   if (cnt == 5'd17) state_nxt = READY;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore status outputs
  always_comb begin
    busy      = (state == KEY_EXP) || (state == CRYPT);
    key_ready = (state == READY) || (state == CRYPT);
  end

  // Step counter, result register and completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      end_signal  <= 1'b0;
      text_output <= '0;
    end else begin
      end_signal <= 1'b0;
      if (state_nxt != state || !busy) cnt <= '0;
      else                             cnt <= cnt + 5'd1;
      if (state == CRYPT && cnt == 5'd17) begin
        end_signal  <= 1'b1;
        text_output <= {r1 ^ wo3, r0 ^ wo2, r3 ^ wo1, r2 ^ wo0};
      end
    end
  end

  // Key lists, block state and subkey file; subkeys survive reset
  always_ff @(posedge clk) begin
    if (key_acc) begin
      me_q <= me_d;
      mo_q <= mo_d;
      s_q  <= s_d;
    end
    if (kx) begin
      sk[{cnt, 1'b0}] <= k_even;
      sk[{cnt, 1'b1}] <= k_odd;
    end
    if (start_acc) begin
      dec_q            <= enc_dec;
      {r3, r2, r1, r0} <= text_input;
    end else if (state == CRYPT) begin
      if (cnt == 5'd0) begin
        r0 <= r0 ^ wi0;
        r1 <= r1 ^ wi1;
        r2 <= r2 ^ wi2;
        r3 <= r3 ^ wi3;
      end else if (cnt <= 5'd16) begin
        r0 <= n0;
        r1 <= n1;
        r2 <= r0;
        r3 <= r1;
      end
    end
  end

endmodule

// File: tb/tb_twofish_iter_core.sv
// Directed bench for twofish_iter_core with 128/192/256-bit instances sharing stimulus.
module tb_twofish_iter_core;

  localparam logic [127:0] CT128 = 128'h5AC3E82A2FECBFB6322C12F65C9F589F;
  localparam logic [127:0] CT192 = 128'h0191C18F1760F85344BD6589781FA7EF;
  localparam logic [127:0] CT256 = 128'h6F21C80C7001FCD71B2CC94D9D73FF57;

  logic         clk = 1'b0;
  logic         rst, key_load, start, enc_dec;
  logic [255:0] key;
  logic [127:0] text_input;
  logic [2:0]   key_ready_v, busy_v, end_v;
  logic [127:0] out128, out192, out256;
  int           passed = 0;
  int           total  = 0;

  always #5 clk = ~clk;

  twofish_iter_core #(.KEY_BITS(128)) u128 (
    .clk(clk), .rst(rst), .key_load(key_load), .key(key), .key_ready(key_ready_v[0]),
    .start(start), .enc_dec(enc_dec), .text_input(text_input), .text_output(out128),
    .busy(busy_v[0]), .end_signal(end_v[0]));
  twofish_iter_core #(.KEY_BITS(192)) u192 (
    .clk(clk), .rst(rst), .key_load(key_load), .key(key), .key_ready(key_ready_v[1]),
    .start(start), .enc_dec(enc_dec), .text_input(text_input), .text_output(out192),
    .busy(busy_v[1]), .end_signal(end_v[1]));
  twofish_iter_core #(.KEY_BITS(256)) u256 (
    .clk(clk), .rst(rst), .key_load(key_load), .key(key), .key_ready(key_ready_v[2]),
    .start(start), .enc_dec(enc_dec), .text_input(text_input), .text_output(out256),
    .busy(busy_v[2]), .end_signal(end_v[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start, then scramble enc_dec/text_input and count cycles to end_signal
  task automatic run_block(input logic [127:0] pt, input logic dec, output int lat);
    text_input = pt;
    enc_dec    = dec;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    enc_dec    = ~dec;
    text_input = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    lat = 0;
    while (end_v[0] !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; key_load = 1'b0; start = 1'b0; enc_dec = 1'b0;
    key = '0; text_input = '0;
    tick(); tick();
    total++; if (key_ready_v !== 3'b000) $display("FAIL reset_key_ready: got %b expected 000", key_ready_v); else passed++;
    total++; if (busy_v !== 3'b000) $display("FAIL reset_busy: got %b expected 000", busy_v); else passed++;
    total++; if (end_v !== 3'b000) $display("FAIL reset_end: got %b expected 000", end_v); else passed++;
    total++; if (out128 !== 128'h0) $display("FAIL reset_text_output: got %h expected 0", out128); else passed++;
    rst = 1'b0;
    start = 1'b1; tick(); start = 1'b0; tick();
    total++; if (busy_v[0] !== 1'b0) $display("FAIL idle_start_ignored: got busy %b expected 0", busy_v[0]); else passed++;
  endtask

  task automatic test_key_exp();
    int cyc = 0;
    int ends = 0;
    key = '0; key_load = 1'b1; tick(); key_load = 1'b0;
    start = 1'b1;
    total++; if (busy_v[0] !== 1'b1 || key_ready_v[0] !== 1'b0)
      $display("FAIL keyexp_entry: got busy %b key_ready %b expected 1 0", busy_v[0], key_ready_v[0]); else passed++;
    while (key_ready_v[0] !== 1'b1 && cyc < 60) begin
      tick(); cyc++;
      if (end_v[0] === 1'b1) ends++;
    end
    start = 1'b0;
    total++; if (cyc != 20) $display("FAIL keyexp_latency: got %0d expected 20", cyc); else passed++;
    total++; if (ends != 0) $display("FAIL keyexp_start_ignored: got %0d end pulses expected 0", ends); else passed++;
    total++; if (key_ready_v !== 3'b111) $display("FAIL keyexp_all_ready: got %b expected 111", key_ready_v); else passed++;
    tick();
    total++; if (busy_v[0] !== 1'b0) $display("FAIL ready_not_busy: got %b expected 0", busy_v[0]); else passed++;
  endtask

  task automatic test_encrypt_128();
    int lat;
    run_block(128'h0, 1'b0, lat);
    total++; if (lat != 18) $display("FAIL enc128_latency: got %0d expected 18", lat); else passed++;
    total++; if (out128 !== CT128) $display("FAIL enc128_result: got %h expected %h", out128, CT128); else passed++;
    tick();
    total++; if (end_v[0] !== 1'b0) $display("FAIL enc128_end_pulse: got %b expected 0", end_v[0]); else passed++;
    total++; if (out128 !== CT128) $display("FAIL enc128_hold: got %h expected %h", out128, CT128); else passed++;
  endtask

  task automatic test_decrypt_128();
    int lat;
    run_block(CT128, 1'b1, lat);
    total++; if (lat != 18) $display("FAIL dec128_latency: got %0d expected 18", lat); else passed++;
    total++; if (out128 !== 128'h0) $display("FAIL dec128_result: got %h expected 0", out128); else passed++;
  endtask

  task automatic test_key_sizes();
    int lat;
    run_block(128'h0, 1'b0, lat);
    total++; if (end_v !== 3'b111) $display("FAIL sizes_end: got %b expected 111", end_v); else passed++;
    total++; if (out192 !== CT192) $display("FAIL enc192_result: got %h expected %h", out192, CT192); else passed++;
    total++; if (out256 !== CT256) $display("FAIL enc256_result: got %h expected %h", out256, CT256); else passed++;
  endtask

  task automatic test_back_to_back();
    int lat;
    run_block(128'h0, 1'b0, lat);
    run_block(CT128, 1'b1, lat);
    total++; if (lat != 18) $display("FAIL b2b_latency: got %0d expected 18", lat); else passed++;
    total++; if (out128 !== 128'h0) $display("FAIL b2b_result: got %h expected 0", out128); else passed++;
  endtask

  task automatic test_busy_ignores();
    int lat = 0;
    text_input = '0; enc_dec = 1'b0; start = 1'b1; tick(); start = 1'b0;
    repeat (4) begin tick(); lat++; end
    text_input = 128'h0123456789ABCDEF_FEDCBA9876543210; enc_dec = 1'b1;
    start = 1'b1; tick(); lat++; start = 1'b0;
    key = '1; key_load = 1'b1; tick(); lat++; key_load = 1'b0; key = '0;
    while (end_v[0] !== 1'b1 && lat < 40) begin tick(); lat++; end
    total++; if (lat != 18) $display("FAIL busy_latency: got %0d expected 18", lat); else passed++;
    total++; if (out128 !== CT128) $display("FAIL busy_result: got %h expected %h", out128, CT128); else passed++;
    total++; if (key_ready_v[0] !== 1'b1) $display("FAIL busy_keyload_ignored: got %b expected 1", key_ready_v[0]); else passed++;
    tick();
  endtask

  task automatic test_start_keyload_same();
    int cyc = 0;
    int ends = 0;
    key = '0; key_load = 1'b1; start = 1'b1; text_input = '0; enc_dec = 1'b0;
    tick();
    key_load = 1'b0; start = 1'b0;
    total++; if (busy_v[0] !== 1'b1 || key_ready_v[0] !== 1'b0)
      $display("FAIL collide_keyexp: got busy %b key_ready %b expected 1 0", busy_v[0], key_ready_v[0]); else passed++;
    while (key_ready_v[0] !== 1'b1 && cyc < 60) begin
      tick(); cyc++;
      if (end_v[0] === 1'b1) ends++;
    end
    repeat (3) begin tick(); if (end_v[0] === 1'b1) ends++; end
    total++; if (cyc != 20) $display("FAIL collide_latency: got %0d expected 20", cyc); else passed++;
    total++; if (ends != 0) $display("FAIL collide_no_end: got %0d end pulses expected 0", ends); else passed++;
  endtask

  task automatic test_reset_mid_crypt();
    int ends = 0;
    int readies = 0;
    text_input = '0; enc_dec = 1'b0; start = 1'b1; tick(); start = 1'b0;
    repeat (9) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    total++; if (busy_v[0] !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy_v[0]); else passed++;
    total++; if (key_ready_v[0] !== 1'b0) $display("FAIL rstmid_key_ready: got %b expected 0", key_ready_v[0]); else passed++;
    total++; if (out128 !== 128'h0) $display("FAIL rstmid_text_output: got %h expected 0", out128); else passed++;
    repeat (25) begin
      if (end_v[0] === 1'b1) ends++;
      if (key_ready_v[0] === 1'b1) readies++;
      tick();
    end
    total++; if (ends != 0) $display("FAIL rstmid_no_end: got %0d end pulses expected 0", ends); else passed++;
    total++; if (readies != 0) $display("FAIL rstmid_stays_unready: got %0d ready cycles expected 0", readies); else passed++;
  endtask

  task automatic test_recovery();
    int cyc = 0;
    int lat;
    key = '0; key_load = 1'b1; tick(); key_load = 1'b0;
    while (key_ready_v[0] !== 1'b1 && cyc < 60) begin tick(); cyc++; end
    total++; if (cyc != 20) $display("FAIL recover_keyexp: got %0d expected 20", cyc); else passed++;
    run_block(128'h0, 1'b0, lat);
    total++; if (out128 !== CT128) $display("FAIL recover_result: got %h expected %h", out128, CT128); else passed++;
  endtask

  initial begin
    test_reset();
    test_key_exp();
    test_encrypt_128();
    test_decrypt_128();
    test_key_sizes();
    test_back_to_back();
    test_busy_ignores();
    test_start_keyload_same();
    test_reset_mid_crypt();
    test_recovery();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
